// File: rtl/risc16_pkg.sv
// Shared RISC-16 definitions: opcodes, PC-select codes, instruction field helpers.
package risc16_pkg;

    localparam int unsigned XLEN   = 16;
    localparam int unsigned IMM_W  = 7;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_e;

    // Next-PC select codes, shared with the PC block.
    localparam logic [SEL_W-1:0] PC_SEQ = 2'b00;  // pc + 1
    localparam logic [SEL_W-1:0] PC_BR  = 2'b01;  // pc + 1 + imm7
    localparam logic [SEL_W-1:0] PC_ABS = 2'b10;  // alu_out

    // Most negative 7-bit offset; decrementing it would wrap.
    localparam logic [IMM_W-1:0] IMM_MIN = 7'h40;

    // IF/ID pipeline register payload.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifid_t;

    function automatic opcode_e opc_of(input logic [XLEN-1:0] instr);
        return opcode_e'(instr[15:13]);
    endfunction

    function automatic logic [REG_W-1:0] rega_of(input logic [XLEN-1:0] instr);
        return instr[12:10];
    endfunction

    function automatic logic [REG_W-1:0] regb_of(input logic [XLEN-1:0] instr);
        return instr[9:7];
    endfunction

    function automatic logic [IMM_W-1:0] imm_of(input logic [XLEN-1:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/risc16_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module risc16_sat_cnt
    import risc16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/risc16_fetch_ctrl.sv
// Fetch-side control: IF/ID register, BEQ/JALR resolution in ID, PC select/offset
// generation and wrong-path kill, plus retire/flush event counters.
module risc16_fetch_ctrl
    import risc16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             rs_eq,
    output logic [SEL_W-1:0] sel,
    output logic [IMM_W-1:0] imm7,
    output logic             tgt_sel,
    output logic [XLEN-1:0]  tgt,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ifid_t            ifid_q;
    ifid_t            ifid_d;
    opcode_e          id_opc;
    logic [IMM_W-1:0] id_imm;
    logic             redirect;

    assign id_opc = opc_of(ifid_q.instr);
    assign id_imm = imm_of(ifid_q.instr);

    // Redirect decision from the live ID instruction and the register compare.
    always_comb begin
        redirect = 1'b0;
        if (ifid_q.valid) begin
            case (id_opc)
                OP_BEQ:  redirect = rs_eq;
                OP_JALR: redirect = 1'b1;
                default: redirect = 1'b0;
            endcase
        end
    end

    // PC select and offset; the PC has already moved to id_pc+1, so BR offsets are
    // pre-decremented, and the one offset that cannot be decremented uses the
    // absolute target instead.
    always_comb begin
        sel     = PC_SEQ;
        imm7    = '0;
        tgt_sel = 1'b0;
        if (redirect) begin
            if (id_opc == OP_JALR) begin
                sel = PC_ABS;
            end else if (id_imm == IMM_MIN) begin
                sel     = PC_ABS;
                tgt_sel = 1'b1;
            end else begin
                sel  = PC_BR;
                imm7 = id_imm - IMM_W'(1);
            end
        end
    end

    // Absolute branch target, modulo 2^16.
    assign tgt = ifid_q.pc + XLEN'(1) + sext_imm(id_imm);

    // Next IF/ID contents; the slot fetched during a redirect is killed.
    always_comb begin
        ifid_d.valid = !redirect;
        ifid_d.instr = imem_rdata;
        ifid_d.pc    = pc;
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_q <= '0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign id_valid = ifid_q.valid;
    assign id_instr = ifid_q.instr;
    assign id_pc    = ifid_q.pc;

    risc16_sat_cnt u_retire_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_en (ifid_q.valid),
        .cnt    (retire_cnt)
    );

    risc16_sat_cnt u_flush_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_en (redirect),
        .cnt    (flush_cnt)
    );

endmodule

// File: tb/tb_risc16_fetch_ctrl.sv
// Bench for risc16_fetch_ctrl: the bench acts as PC block and instruction memory,
// queues the expected ID-stage view of each fetch, and compares it one cycle later.
module tb_risc16_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] pc_r;
    logic [15:0] imem_rdata;
    logic        rs_eq;
    logic [1:0]  sel;
    logic [6:0]  imm7;
    logic        tgt_sel;
    logic [15:0] tgt;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] retire_cnt;
    logic [15:0] flush_cnt;

    logic [15:0] regb_val;
    int          n_chk;
    int          n_pass;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        valid;
        logic        rs;
        logic [1:0]  sel;
        logic [6:0]  imm;
        logic        tsel;
        logic [15:0] tgt;
        logic [15:0] npc;
    } exp_t;

    exp_t sb_q[$];

    risc16_fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc_r),
        .imem_rdata (imem_rdata),
        .rs_eq      (rs_eq),
        .sel        (sel),
        .imm7       (imm7),
        .tgt_sel    (tgt_sel),
        .tgt        (tgt),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .retire_cnt (retire_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    endtask

    // PC block behaviour driven by the DUT's select outputs.
    function automatic logic [15:0] pc_next();
        case (sel)
            2'b01:   return pc_r + 16'd1 + {{9{imm7[6]}}, imm7};
            2'b10:   return tgt_sel ? tgt : regb_val;
            default: return pc_r + 16'd1;
        endcase
    endfunction

    function automatic exp_t mk(input logic [15:0] p, input logic [15:0] ins, input logic v,
                                input logic r, input logic [1:0] s, input logic [6:0] im,
                                input logic ts, input logic [15:0] tg, input logic [15:0] np);
        exp_t e;
        e.pc = p; e.instr = ins; e.valid = v; e.rs = r; e.sel = s;
        e.imm = im; e.tsel = ts; e.tgt = tg; e.npc = np;
        return e;
    endfunction

    // One cycle: check the ID entry against its queued expectation, fetch a new one.
    task automatic slot(input logic [15:0] instr, input logic v, input logic r,
                        input logic [1:0] s, input logic [6:0] im, input logic ts,
                        input logic [15:0] tg, input logic [15:0] np);
        exp_t        e;
        logic [15:0] npc;
        chk("sb_depth", 16'(sb_q.size()), 16'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        imem_rdata = instr;
        rs_eq      = e.rs;
        #1;
        chk("id_valid", 16'(id_valid), 16'(e.valid));
        chk("id_pc",    id_pc,         e.pc);
        chk("id_instr", id_instr,      e.instr);
        chk("sel",      16'(sel),      16'(e.sel));
        chk("imm7",     16'(imm7),     16'(e.imm));
        chk("tgt_sel",  16'(tgt_sel),  16'(e.tsel));
        chk("tgt",      tgt,           e.tgt);
        npc = pc_next();
        chk("next_pc",  npc,           e.npc);
        sb_q.push_back(mk(pc_r, instr, v, r, s, im, ts, tg, np));
        @(posedge clk);
        #1;
        pc_r = npc;
    endtask

    task automatic seq(input logic [15:0] instr);
        slot(instr, 1'b1, 1'b0, 2'b00, 7'd0, 1'b0, pc_r + 16'd1, pc_r + 16'd2);
    endtask

    task automatic kill(input logic [15:0] instr, input logic r, input logic [15:0] tg,
                        input logic [15:0] np);
        slot(instr, 1'b0, r, 2'b00, 7'd0, 1'b0, tg, np);
    endtask

    task automatic cnts(input logic [15:0] ret, input logic [15:0] fl);
        chk("retire_cnt", retire_cnt, ret);
        chk("flush_cnt",  flush_cnt,  fl);
    endtask

    // Release reset just after an edge and seed the queue with the reset ID view.
    task automatic release_reset();
        reset = 1'b1;
        pc_r  = 16'h0000;
        sb_q.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00, 7'd0, 1'b0,
                          16'h0001, 16'h0001));
    endtask

    initial begin
        exp_t e;
        n_chk      = 0;
        n_pass     = 0;
        reset      = 1'b0;
        pc_r       = 16'h0000;
        imem_rdata = 16'hC505;
        rs_eq      = 1'b1;
        regb_val   = 16'h0000;

        // Reset held for three cycles with a taken-branch pattern on the inputs.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_id_valid", 16'(id_valid), 16'd0);
        chk("rst_sel",      16'(sel),      16'd0);
        chk("rst_imm7",     16'(imm7),     16'd0);
        chk("rst_tgt_sel",  16'(tgt_sel),  16'd0);
        chk("rst_tgt",      tgt,           16'h0001);
        chk("rst_id_pc",    id_pc,         16'h0000);
        chk("rst_id_instr", id_instr,      16'h0000);
        cnts(16'd0, 16'd0);
        release_reset();

        // Straight-line ADDs from address 0.
        for (int i = 0; i < 16; i++) begin
            seq(16'(16'h0000 | (i << 7)));
            if (i == 8) cnts(16'd8, 16'd0);
        end
        cnts(16'd15, 16'd0);

        // Taken BEQ imm=+5 at 0x0010; wrong-path BEQ at 0x0011 is killed despite rs_eq.
        slot(16'hC505, 1'b1, 1'b1, 2'b01, 7'd4, 1'b0, 16'h0016, 16'h0016);
        kill(16'hC505, 1'b1, 16'h0017, 16'h0017);
        seq(16'h0480);
        cnts(16'd17, 16'd1);

        // Not-taken BEQ at 0x0017.
        slot(16'hC505, 1'b1, 1'b0, 2'b00, 7'd0, 1'b0, 16'h001D, 16'h0019);
        seq(16'h0500);
        seq(16'h0580);
        cnts(16'd20, 16'd1);

        // JALR at 0x001A to 0x00FF, then BEQ imm=-64 at 0x0100.
        regb_val = 16'h00FF;
        slot(16'hEE00, 1'b1, 1'b0, 2'b10, 7'd0, 1'b0, 16'h001B, 16'h00FF);
        kill(16'h0600, 1'b0, 16'h001C, 16'h0100);
        seq(16'h0680);
        slot(16'hC540, 1'b1, 1'b1, 2'b10, 7'd0, 1'b1, 16'h00C1, 16'h00C1);
        kill(16'h0700, 1'b0, 16'h0102, 16'h00C2);
        seq(16'h0780);
        cnts(16'd24, 16'd3);

        // JALR at 0x00C2 to 0xFFFF, then BEQ imm=+1 wrapping to 0x0001.
        regb_val = 16'hFFFF;
        slot(16'hEE00, 1'b1, 1'b0, 2'b10, 7'd0, 1'b0, 16'h00C3, 16'hFFFF);
        kill(16'h0800, 1'b0, 16'h00C4, 16'h0000);
        slot(16'hC501, 1'b1, 1'b1, 2'b01, 7'd0, 1'b0, 16'h0001, 16'h0001);
        kill(16'h0880, 1'b0, 16'h0001, 16'h0002);
        seq(16'h0900);
        cnts(16'd27, 16'd5);

        // Taken BEQ imm=-3 at 0x0002 back to 0x0000.
        slot(16'hC57D, 1'b1, 1'b1, 2'b01, 7'h7C, 1'b0, 16'h0000, 16'h0000);
        kill(16'h0980, 1'b0, 16'h0004, 16'h0001);
        seq(16'h0A00);
        cnts(16'd29, 16'd6);

        // Taken BEQ at 0x0001 interrupted by reset mid-cycle.
        slot(16'hC505, 1'b1, 1'b1, 2'b01, 7'd4, 1'b0, 16'h0007, 16'h0007);
        e = sb_q.pop_front();
        rs_eq      = e.rs;
        imem_rdata = 16'h0000;
        #1;
        chk("pre_rst_sel",  16'(sel),  16'(e.sel));
        chk("pre_rst_imm7", 16'(imm7), 16'(e.imm));
        chk("pre_rst_tgt",  tgt,       e.tgt);
        cnts(16'd30, 16'd6);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_sel",      16'(sel),      16'd0);
        chk("mid_rst_imm7",     16'(imm7),     16'd0);
        chk("mid_rst_tgt_sel",  16'(tgt_sel),  16'd0);
        chk("mid_rst_id_valid", 16'(id_valid), 16'd0);
        chk("mid_rst_tgt",      tgt,           16'h0001);
        cnts(16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        seq(16'h0A80);
        seq(16'h0B00);
        seq(16'h0B80);
        cnts(16'd2, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
